// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath controls.
// Optional macro ZERO_EXTEND_LOGIC_EN: zero-extend immediates for andi/ori (default: always sign-extend).
module multicycle_controller (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic [1:0] RegDst,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtSel,
    output logic [1:0] PCSrc,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic       mRD,
    output logic       mWR,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_t state_reg;
    state_t state_next;

    logic       is_rtype;
    logic       is_iarith;
    logic       is_ls;
    logic       is_br;
    logic       is_jump;
    logic [2:0] r_alu_op;
    logic [2:0] i_alu_op;

    logic pc_wre_raw;
    logic ir_wre_raw;
    logic reg_wre_raw;
    logic m_rd_raw;
    logic m_wr_raw;

    // Instruction class decode; an unrecognised funct leaves is_rtype low so it falls to the NOP path.
    always_comb begin
        is_rtype = 1'b0;
        r_alu_op = 3'b000;
        if (op == OP_RTYPE) begin
            is_rtype = 1'b1;
            case (funct)
                6'b100000: r_alu_op = 3'b000;
                6'b100010: r_alu_op = 3'b001;
                6'b100100: r_alu_op = 3'b010;
                6'b100101: r_alu_op = 3'b011;
                6'b101010: r_alu_op = 3'b100;
                default:   is_rtype = 1'b0;
            endcase
        end
    end

    always_comb begin
        is_iarith = 1'b1;
        i_alu_op  = 3'b000;
        case (op)
            OP_ADDI: i_alu_op = 3'b000;
            OP_ANDI: i_alu_op = 3'b010;
            OP_ORI:  i_alu_op = 3'b011;
            OP_SLTI: i_alu_op = 3'b100;
            default: is_iarith = 1'b0;
        endcase
    end

    assign is_ls   = (op == OP_LW)  || (op == OP_SW);
    assign is_br   = (op == OP_BEQ) || (op == OP_BNE);
    assign is_jump = (op == OP_J)   || (op == OP_JAL);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= S_IF;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_IF;
        case (state_reg)
            S_IF: state_next = S_ID;
            S_ID: begin
                if (is_rtype || is_iarith) state_next = S_EXE_AL;
                else if (is_ls)            state_next = S_EXE_LS;
                else if (is_br)            state_next = S_EXE_BR;
                else if (op == OP_HALT)    state_next = S_HALT;
                else                       state_next = S_IF;
            end
            S_EXE_AL: state_next = S_WB_AL;
            S_WB_AL:  state_next = S_IF;
            S_EXE_LS: state_next = S_MEM;
            S_MEM:    state_next = (op == OP_LW) ? S_WB_LD : S_IF;
            S_WB_LD:  state_next = S_IF;
            S_EXE_BR: state_next = S_IF;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IF;
        endcase
    end

    always_comb begin
        pc_wre_raw  = 1'b0;
        ir_wre_raw  = 1'b0;
        reg_wre_raw = 1'b0;
        m_rd_raw    = 1'b0;
        m_wr_raw    = 1'b0;
        RegDst      = 2'b00;
        ALUSrcB     = 1'b0;
        ALUOp       = 3'b000;
        PCSrc       = 2'b00;
        DBDataSrc   = 1'b0;
        WrRegDSrc   = 1'b0;
        case (state_reg)
            S_IF: ir_wre_raw = 1'b1;
            S_ID: begin
                if (is_jump) begin
                    pc_wre_raw = 1'b1;
                    PCSrc      = 2'b10;
                    if (op == OP_JAL) reg_wre_raw = 1'b1;
                end else if (!(is_rtype || is_iarith || is_ls || is_br || op == OP_HALT)) begin
                    pc_wre_raw = 1'b1;
                end
            end
            S_EXE_AL, S_WB_AL: begin
                ALUOp   = is_rtype ? r_alu_op : i_alu_op;
                ALUSrcB = ~is_rtype;
                if (state_reg == S_WB_AL) begin
                    reg_wre_raw = 1'b1;
                    RegDst      = is_rtype ? 2'b10 : 2'b01;
                    WrRegDSrc   = 1'b1;
                    pc_wre_raw  = 1'b1;
                end
            end
            S_EXE_LS: ALUSrcB = 1'b1;
            S_MEM: begin
                ALUSrcB = 1'b1;
                if (op == OP_LW) begin
                    m_rd_raw = 1'b1;
                end else begin
                    m_wr_raw   = 1'b1;
                    pc_wre_raw = 1'b1;
                end
            end
            S_WB_LD: begin
                ALUSrcB     = 1'b1;
                reg_wre_raw = 1'b1;
                RegDst      = 2'b01;
                WrRegDSrc   = 1'b1;
                DBDataSrc   = 1'b1;
                pc_wre_raw  = 1'b1;
            end
            S_EXE_BR: begin
                ALUOp      = 3'b001;
                pc_wre_raw = 1'b1;
                if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) PCSrc = 2'b01;
            end
            default: ;
        endcase
    end

    // Enables are masked while Reset is high so an aborted instruction writes nothing.
    assign PCWre  = pc_wre_raw  & ~Reset;
    assign IRWre  = ir_wre_raw  & ~Reset;
    assign RegWre = reg_wre_raw & ~Reset;
    assign mRD    = m_rd_raw    & ~Reset;
    assign mWR    = m_wr_raw    & ~Reset;
    assign state  = state_reg;

`ifdef ZERO_EXTEND_LOGIC_EN
    assign ExtSel = ~((op == OP_ANDI) || (op == OP_ORI));
`else
    assign ExtSel = 1'b1;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes per-cycle expected controls, monitor compares at negedge.
module tb_multicycle_controller;

    logic       CLK;
    logic       Reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCWre, IRWre, RegWre, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, mRD, mWR;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       pc_wre;
        logic       ir_wre;
        logic       reg_wre;
        logic [1:0] reg_dst;
        logic       alu_src_b;
        logic [2:0] alu_op;
        logic       ext_sel;
        logic [1:0] pc_src;
        logic       db_data_src;
        logic       wr_reg_d_src;
        logic       m_rd;
        logic       m_wr;
    } exp_t;

`ifdef ZERO_EXTEND_LOGIC_EN
    localparam logic ORI_EXT = 1'b0;
`else
    localparam logic ORI_EXT = 1'b1;
`endif

    exp_t  exp_q[$];
    string name_q[$];
    int    n_compared;
    int    n_mismatched;

    multicycle_controller dut (
        .CLK(CLK), .Reset(Reset), .op(op), .funct(funct), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel), .PCSrc(PCSrc),
        .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .mRD(mRD), .mWR(mWR),
        .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic exp_t base(input logic [3:0] st);
        exp_t e;
        e = '0;
        e.st = st;
        e.ext_sel = 1'b1;
        return e;
    endfunction

    function automatic exp_t fetch();
        exp_t e;
        e = base(4'd0);
        e.ir_wre = 1'b1;
        return e;
    endfunction

    task automatic step(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every cycle the controller presents a full control word.
    always @(negedge CLK) begin
        exp_t  act;
        exp_t  req;
        string nm;
        if (exp_q.size() > 0) begin
            req = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = '{state, PCWre, IRWre, RegWre, RegDst, ALUSrcB, ALUOp, ExtSel,
                    PCSrc, DBDataSrc, WrRegDSrc, mRD, mWR};
            n_compared++;
            if (act !== req) begin
                n_mismatched++;
                $display("FAIL %s: actual=%05h required=%05h (state %0h vs %0h)",
                         nm, act, req, act.st, req.st);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        n_compared   = 0;
        n_mismatched = 0;
        Reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        @(posedge CLK);
        #1;

        // Reset held three cycles: enables all low, state IF.
        for (int i = 0; i < 3; i++) step("reset_hold", base(4'd0));
        Reset = 1'b0;

        // lw: five cycles.
        op = 6'b100011;
        step("lw_if", fetch());
        step("lw_id", base(4'd1));
        e = base(4'd2); e.alu_src_b = 1'b1;
        step("lw_exe", e);
        e = base(4'd3); e.alu_src_b = 1'b1; e.m_rd = 1'b1;
        step("lw_mem", e);
        e = base(4'd4); e.alu_src_b = 1'b1; e.reg_wre = 1'b1; e.reg_dst = 2'b01;
        e.wr_reg_d_src = 1'b1; e.db_data_src = 1'b1; e.pc_wre = 1'b1;
        step("lw_wb", e);

        // beq taken then not taken.
        op = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            step("beq_if", fetch());
            step("beq_id", base(4'd1));
            e = base(4'd5); e.alu_op = 3'b001; e.pc_wre = 1'b1;
            e.pc_src = z[0] ? 2'b01 : 2'b00;
            step(z[0] ? "beq_taken" : "beq_not_taken", e);
        end

        // bne with zero=0 takes the branch.
        op = 6'b000101; zero = 1'b0;
        step("bne_if", fetch());
        step("bne_id", base(4'd1));
        e = base(4'd5); e.alu_op = 3'b001; e.pc_wre = 1'b1; e.pc_src = 2'b01;
        step("bne_taken", e);

        // jal: two cycles, links to $31 in ID.
        op = 6'b000011;
        step("jal_if", fetch());
        e = base(4'd1); e.pc_wre = 1'b1; e.pc_src = 2'b10; e.reg_wre = 1'b1;
        step("jal_id", e);

        // ori: zero-extension only when the option is built in.
        op = 6'b001101;
        e = fetch(); e.ext_sel = ORI_EXT;
        step("ori_if", e);
        e = base(4'd1); e.ext_sel = ORI_EXT;
        step("ori_id", e);
        e = base(4'd6); e.ext_sel = ORI_EXT; e.alu_op = 3'b011; e.alu_src_b = 1'b1;
        step("ori_exe", e);
        e.st = 4'd7; e.reg_wre = 1'b1; e.reg_dst = 2'b01; e.wr_reg_d_src = 1'b1; e.pc_wre = 1'b1;
        step("ori_wb", e);

        // R-type slt: rd destination, register operand.
        op = 6'b000000; funct = 6'b101010;
        step("slt_if", fetch());
        step("slt_id", base(4'd1));
        e = base(4'd6); e.alu_op = 3'b100;
        step("slt_exe", e);
        e.st = 4'd7; e.reg_wre = 1'b1; e.reg_dst = 2'b10; e.wr_reg_d_src = 1'b1; e.pc_wre = 1'b1;
        step("slt_wb", e);

        // sw: four cycles, single mWR pulse with PC update.
        op = 6'b101011;
        step("sw_if", fetch());
        step("sw_id", base(4'd1));
        e = base(4'd2); e.alu_src_b = 1'b1;
        step("sw_exe", e);
        e = base(4'd3); e.alu_src_b = 1'b1; e.m_wr = 1'b1; e.pc_wre = 1'b1;
        step("sw_mem", e);

        // Undefined op and undefined funct execute as NOP.
        op = 6'b010101;
        step("undef_op_if", fetch());
        e = base(4'd1); e.pc_wre = 1'b1;
        step("undef_op_id", e);
        op = 6'b000000; funct = 6'b111000;
        step("undef_funct_if", fetch());
        step("undef_funct_id", e);

        // Reset mid-lw aborts with no enables, then restarts at IF.
        op = 6'b100011;
        step("abort_if", fetch());
        step("abort_id", base(4'd1));
        Reset = 1'b1;
        e = base(4'd2); e.alu_src_b = 1'b1;
        step("abort_reset", e);
        Reset = 1'b0;
        step("abort_restart", fetch());

        // halt: state 1000 sticks until reset.
        op = 6'b111111;
        step("halt_id", base(4'd1));
        for (int i = 0; i < 10; i++) step("halt_hold", base(4'd8));
        Reset = 1'b1;
        step("halt_reset", base(4'd8));
        Reset = 1'b0;
        step("halt_restart", fetch());

        @(negedge CLK);
        #1;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences the multi-cycle MIPS datapath: program counter, instruction register, register file, ALU, data memory and immediate extender. Each instruction takes 2–5 cycles through IF/ID/EXE/MEM/WB states. In every state the block drives the datapath control lines, including the sign/zero-extension select for the 16-bit immediate. It sits between the instruction register and the shared datapath in the CPU top level.

## Interface
- No parameters.
- CLK  input  1  system clock, all state changes on rising edge
- Reset  input  1  synchronous, active-high; forces state IF
- op  input  6  opcode field of instruction register (IR[31:26])
- funct  input  6  function field (IR[5:0]), used only when op=000000
- zero  input  1  ALU result-is-zero flag
- PCWre  output  1  PC write enable
- IRWre  output  1  instruction register write enable
- RegWre  output  1  register file write enable
- RegDst  output  2  write register: 00=$31, 01=rt, 10=rd
- ALUSrcB  output  1  0=register rt, 1=extended immediate
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- ExtSel  output  1  0=zero-extend, 1=sign-extend immediate
- PCSrc  output  2  00=PC+4, 01=branch target, 10=jump target
- DBDataSrc  output  1  write-back data: 0=ALU, 1=memory
- WrRegDSrc  output  1  0=PC+4 (jal), 1=DBDataSrc mux
- mRD  output  1  data memory read
- mWR  output  1  data memory write
- state  output  4  current state, for debug

## Operation
- Supported ops:
  - R-type 000000: funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt
  - addi 001000, andi 001100, ori 001101, slti 001010
  - lw 100011, sw 101011
  - beq 000100, bne 000101
  - j 000010, jal 000011
  - halt 111111
- States: IF=0000, ID=0001, EXE_LS=0010, MEM=0011, WB_LD=0100, EXE_BR=0101, EXE_AL=0110, WB_AL=0111, HALT=1000.
- Transitions:
  - IF→ID
  - ID→EXE_AL (R-type, I-arith), EXE_LS (lw/sw), EXE_BR (beq/bne), IF (j, jal, undefined op, undefined funct), HALT (halt)
  - EXE_AL→WB_AL→IF
  - EXE_LS→MEM
  - MEM→WB_LD (lw) or IF (sw)
  - WB_LD→IF
  - EXE_BR→IF
  - HALT→HALT until Reset.
- Outputs are decoded combinationally from state, op and funct; op/funct are held stable by the IR from ID onward. Any signal not listed below is 0.
- IF: IRWre=1.
- ID:
  - j: PCWre=1, PCSrc=10.
  - jal: PCWre=1, PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0.
  - Undefined op/funct: PCWre=1, PCSrc=00 (executed as NOP).
- EXE_AL/WB_AL:
  - ALUOp per funct (R-type) or per op: addi=000, andi=010, ori=011, slti=100.
  - ALUSrcB=1 for I-type.
  - WB_AL adds RegWre=1, RegDst=10 (R-type) or 01 (I-type), WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00.
- EXE_LS/MEM/WB_LD:
  - ALUOp=000, ALUSrcB=1.
  - MEM: mRD=1 (lw) or mWR=1 (sw); for sw, also PCWre=1, PCSrc=00.
  - WB_LD: RegWre=1, RegDst=01, WrRegDSrc=1, DBDataSrc=1, PCWre=1, PCSrc=00.
- EXE_BR:
  - ALUOp=001, PCWre=1.
  - PCSrc=01 if (beq&&zero)||(bne&&!zero), else 00.
- HALT: all enables 0.
- ExtSel: 1 in every state except as set under Configuration.

## Timing
- Cycles per instruction, IF to next IF: j/jal 2, beq/bne 3, R-type/I-arith/sw 4, lw 5.
- PCWre is high for exactly one cycle per instruction: the last cycle before returning to IF.
- IRWre is high only in IF.
- mWR is a single-cycle pulse in MEM.
- Reset:
  - While Reset=1, every output enable (PCWre, IRWre, RegWre, mRD, mWR) is forced 0.
  - The cycle after Reset deasserts, state=IF with IRWre=1; state output reads 0000.
  - Reset asserted mid-instruction aborts it: no further enables issue.
- zero is sampled combinationally in EXE_BR only.

## Configuration
- ZERO_EXTEND_LOGIC_EN
  - Defined: ExtSel=0 whenever op is andi or ori, in any state.
  - Undefined: ExtSel is constant 1 (all immediates sign-extended), and the andi/ori decode logic for ExtSel is not synthesized.

## Test plan
- Reset held 3 cycles, then released → all enables 0 during reset; next cycle state=0000, IRWre=1.
- lw (op=100011) → states 0000,0001,0010,0011,0100,0000. mRD=1 only in 0011. RegWre=1, DBDataSrc=1 and PCWre=1 only in 0100.
- beq with zero=1, then with zero=0 → 3-cycle sequence each; in EXE_BR, PCSrc=01 then 00; PCWre=1 in both.
- jal → 2 cycles; in ID: PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0.
- ori with imm 16'h8000 → ExtSel=0 with ZERO_EXTEND_LOGIC_EN defined, ExtSel=1 without; ALUOp=011, ALUSrcB=1.
- halt → state 1000 held 10 cycles with all enables 0; Reset then returns state to IF. Undefined op 010101 → ID→IF with PCWre=1, PCSrc=00.
